// File: rtl/elastic_fifo_buffer.sv
// Elastic valid/ready FIFO with opaque (registered) or transparent (bypass-when-empty) output.
// Define ELASTIC_FIFO_BUFFER_OCCUPANCY_EN to expose the registered occupancy count.
module elastic_fifo_buffer #(
  parameter int unsigned DATA_TYPE   = 64,
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned TRANSPARENT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_TYPE-1:0]         ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [DATA_TYPE-1:0]         outs,
  output logic                         outs_valid,
  input  logic                         outs_ready
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
`endif
);

  localparam int unsigned PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_SLOTS - 1);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  // Low during reset and for the first cycle after it, so ins_ready stays registered.
  logic                 live_q;
  logic                 empty, full, bypass;
  logic                 push, pop, wr_en, rd_en;

  assign bypass     = (TRANSPARENT != 0) && empty;
  assign ins_ready  = live_q && !full;
  assign outs_valid = bypass ? (live_q && ins_valid) : !empty;
  assign outs       = bypass ? ins : mem_q[rd_ptr_q];

  assign push  = ins_valid && ins_ready;
  assign pop   = outs_valid && outs_ready;
  // A bypassed token consumed in the same cycle never touches storage.
  assign wr_en = push && !(bypass && pop);
  assign rd_en = pop && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
  end

`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
  localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);

  logic [CntW-1:0] count_q, count_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(NUM_SLOTS));
  assign occupancy = count_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end
`else
  // Equal pointers are ambiguous; full_q tells full from empty.
  logic full_q, full_d;

  assign empty = (rd_ptr_q == wr_ptr_q) && !full_q;
  assign full  = full_q;

  always_comb begin
    full_d = full_q;
    if (wr_en && !rd_en)      full_d = (wr_ptr_d == rd_ptr_q);
    else if (rd_en && !wr_en) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) full_q <= 1'b0;
    else      full_q <= full_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      live_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ins;
  end

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// Directed bench for elastic_fifo_buffer: opaque depth 2 and 3, transparent depth 2.
// Per-instance scoreboards are filled on input handshakes and drained on output handshakes.
module tb_elastic_fifo_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] o2_ins = '0, o3_ins = '0, t2_ins = '0;
  logic       o2_iv = 1'b0, o3_iv = 1'b0, t2_iv = 1'b0;
  logic       o2_or = 1'b0, o3_or = 1'b0, t2_or = 1'b0;
  logic [7:0] o2_outs, o3_outs, t2_outs;
  logic       o2_ir, o3_ir, t2_ir;
  logic       o2_ov, o3_ov, t2_ov;
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
  logic [1:0] o2_occ, o3_occ, t2_occ;
`endif

  elastic_fifo_buffer #(.DATA_TYPE(8), .NUM_SLOTS(2), .TRANSPARENT(0)) u_o2 (
    .clk(clk), .rst(rst), .ins(o2_ins), .ins_valid(o2_iv), .ins_ready(o2_ir),
    .outs(o2_outs), .outs_valid(o2_ov), .outs_ready(o2_or)
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    , .occupancy(o2_occ)
`endif
  );

  elastic_fifo_buffer #(.DATA_TYPE(8), .NUM_SLOTS(3), .TRANSPARENT(0)) u_o3 (
    .clk(clk), .rst(rst), .ins(o3_ins), .ins_valid(o3_iv), .ins_ready(o3_ir),
    .outs(o3_outs), .outs_valid(o3_ov), .outs_ready(o3_or)
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    , .occupancy(o3_occ)
`endif
  );

  elastic_fifo_buffer #(.DATA_TYPE(8), .NUM_SLOTS(2), .TRANSPARENT(1)) u_t2 (
    .clk(clk), .rst(rst), .ins(t2_ins), .ins_valid(t2_iv), .ins_ready(t2_ir),
    .outs(t2_outs), .outs_valid(t2_ov), .outs_ready(t2_or)
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    , .occupancy(t2_occ)
`endif
  );

  logic [7:0] q_o2[$], q_o3[$], q_t2[$];
  int rcv_o3 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are stable from the negedge up to the next rising edge.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (o2_iv && o2_ir) q_o2.push_back(o2_ins);
    if (o2_ov && o2_or) begin
      exp = (q_o2.size() != 0) ? q_o2.pop_front() : 8'bx;
      check("o2_order", 64'(o2_outs), 64'(exp));
    end
    if (o3_iv && o3_ir) q_o3.push_back(o3_ins);
    if (o3_ov && o3_or) begin
      exp = (q_o3.size() != 0) ? q_o3.pop_front() : 8'bx;
      check("o3_order", 64'(o3_outs), 64'(exp));
      rcv_o3++;
    end
    if (t2_iv && t2_ir) q_t2.push_back(t2_ins);
    if (t2_ov && t2_or) begin
      exp = (q_t2.size() != 0) ? q_t2.pop_front() : 8'bx;
      check("t2_order", 64'(t2_outs), 64'(exp));
    end
  end

  initial begin
    int sent;
    int rcv_base;
    logic acc;

    // Reset held with valid inputs.
    o2_iv = 1'b1; o3_iv = 1'b1; t2_iv = 1'b1; t2_ins = 8'h33;
    repeat (3) step();
    check("rst_o2_ir", 64'(o2_ir), 64'd0);
    check("rst_o3_ir", 64'(o3_ir), 64'd0);
    check("rst_t2_ir", 64'(t2_ir), 64'd0);
    check("rst_o2_ov", 64'(o2_ov), 64'd0);
    check("rst_t2_ov", 64'(t2_ov), 64'd0);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("rst_o3_occ", 64'(o3_occ), 64'd0);
`endif
    o2_iv = 1'b0; o3_iv = 1'b0; t2_iv = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_o2_ir_before_edge", 64'(o2_ir), 64'd0);
    step();
    check("rel_o2_ir", 64'(o2_ir), 64'd1);
    check("rel_o3_ir", 64'(o3_ir), 64'd1);
    check("rel_t2_ir", 64'(t2_ir), 64'd1);

    // Opaque streaming, depth 2.
    o2_or = 1'b1;
    check("o2_idle_ov", 64'(o2_ov), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      o2_ins = 8'(i);
      o2_iv  = 1'b1;
      step();
      check("o2_stream_ov", 64'(o2_ov), 64'd1);
      check("o2_stream_outs", 64'(o2_outs), 64'(i));
      check("o2_stream_ir", 64'(o2_ir), 64'd1);
    end
    o2_iv = 1'b0;
    step();
    check("o2_stream_done_ov", 64'(o2_ov), 64'd0);
    o2_or = 1'b0;

    // Fill and backpressure, depth 3.
    o3_or = 1'b0;
    o3_iv = 1'b1;
    o3_ins = 8'h0A; step();
    o3_ins = 8'h0B; step();
    o3_ins = 8'h0C; step();
    check("o3_full_ir", 64'(o3_ir), 64'd0);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("o3_full_occ", 64'(o3_occ), 64'd3);
`endif
    o3_ins = 8'h0D;
    step();
    check("o3_hold_ir", 64'(o3_ir), 64'd0);
    check("o3_hold_ov", 64'(o3_ov), 64'd1);
    check("o3_hold_outs", 64'(o3_outs), 64'h0A);
    o3_or = 1'b1;
    step();
    o3_or = 1'b0;
    check("o3_pop_ir", 64'(o3_ir), 64'd1);
    check("o3_pop_outs", 64'(o3_outs), 64'h0B);
    step();
    o3_iv = 1'b0;
    check("o3_refill_ir", 64'(o3_ir), 64'd0);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("o3_refill_occ", 64'(o3_occ), 64'd3);
`endif
    o3_or = 1'b1;
    repeat (3) step();
    check("o3_drain_ov", 64'(o3_ov), 64'd0);
    o3_or = 1'b0;

    // Random valid/ready across pointer wrap, depth 3.
    sent = 0;
    rcv_base = rcv_o3;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      o3_iv  = 1'($urandom_range(0, 1));
      o3_ins = 8'(sent);
      o3_or  = ($urandom_range(0, 3) != 0);
      acc    = o3_iv && o3_ir;
      step();
      if (acc) sent++;
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
      check("o3_occ_bound", 64'(o3_occ <= 2'd3 && o3_occ == 2'(q_o3.size())), 64'd1);
`endif
    end
    check("o3_rand_sent", 64'(sent), 64'd1000);
    o3_iv = 1'b0;
    o3_or = 1'b1;
    repeat (6) step();
    check("o3_rand_rcv", 64'(rcv_o3 - rcv_base), 64'd1000);
    check("o3_rand_ov", 64'(o3_ov), 64'd0);
    o3_or = 1'b0;

    // Transparent bypass, consumer ready.
    t2_or  = 1'b1;
    t2_ins = 8'h55;
    t2_iv  = 1'b1;
    #1;
    check("t2_bypass_ov", 64'(t2_ov), 64'd1);
    check("t2_bypass_outs", 64'(t2_outs), 64'h55);
    step();
    t2_iv = 1'b0;
    #1;
    check("t2_bypass_after_ov", 64'(t2_ov), 64'd0);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("t2_bypass_occ", 64'(t2_occ), 64'd0);
`endif
    // Transparent, consumer stalled: token is captured.
    t2_or = 1'b0;
    t2_iv = 1'b1;
    step();
    t2_iv = 1'b0;
    check("t2_kept_ov", 64'(t2_ov), 64'd1);
    check("t2_kept_outs", 64'(t2_outs), 64'h55);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("t2_kept_occ", 64'(t2_occ), 64'd1);
`endif
    t2_ins = 8'h66;
    t2_iv  = 1'b1;
    #1;
    check("t2_queued_outs", 64'(t2_outs), 64'h55);
    step();
    t2_iv = 1'b0;
    check("t2_stable_outs", 64'(t2_outs), 64'h55);
    check("t2_full_ir", 64'(t2_ir), 64'd0);
    t2_or = 1'b1;
    step();
    check("t2_second_outs", 64'(t2_outs), 64'h66);
    step();
    check("t2_drain_ov", 64'(t2_ov), 64'd0);
    t2_or = 1'b0;

    // Reset mid-operation with two stored tokens.
    o2_or = 1'b0;
    o2_iv = 1'b1;
    o2_ins = 8'h11; step();
    o2_ins = 8'h22; step();
    o2_iv = 1'b0;
    check("o2_pre_rst_ov", 64'(o2_ov), 64'd1);
`ifdef ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
    check("o2_pre_rst_occ", 64'(o2_occ), 64'd2);
`endif
    rst = 1'b0;
    q_o2.delete();
    #1;
    check("o2_mid_rst_ov", 64'(o2_ov), 64'd0);
    check("o2_mid_rst_ir", 64'(o2_ir), 64'd0);
    step();
    rst = 1'b1;
    step();
    o2_or  = 1'b1;
    o2_ins = 8'h99;
    o2_iv  = 1'b1;
    step();
    o2_iv = 1'b0;
    check("o2_post_rst_ov", 64'(o2_ov), 64'd1);
    check("o2_post_rst_outs", 64'(o2_outs), 64'h99);
    step();
    check("o2_post_rst_drain", 64'(o2_ov), 64'd0);

    check("scoreboards_empty", 64'(q_o2.size() + q_o3.size() + q_t2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_fifo_buffer.md
# elastic_fifo_buffer

Parametrised elastic FIFO buffer that replaces the fixed two-slot opaque-plus-transparent buffer pairs on dataflow channels. It stores up to NUM_SLOTS tokens, keeps full throughput under valid/ready handshaking, and decouples producer and consumer ready paths. A mode parameter selects between a registered output (opaque) and a zero-latency bypass when empty (transparent). The buffering pass instantiates it on any channel: data, condition or result.

## Interface
Parameters:
- DATA_TYPE, 64: token width in bits; must be ≥1.
- NUM_SLOTS, 2: storage depth in tokens; must be ≥1; need not be a power of two.
- TRANSPARENT, 0: 0 = opaque, latency ≥1 cycle; 1 = bypass when empty, latency 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ins  in  DATA_TYPE  input token.
- ins_valid  in  1  producer token valid.
- ins_ready  out  1  buffer can accept a token.
- outs  out  DATA_TYPE  output token.
- outs_valid  out  1  output token valid.
- outs_ready  in  1  consumer accepts the token.
- occupancy  out  $clog2(NUM_SLOTS+1)  stored token count. Present only with ELASTIC_FIFO_BUFFER_OCCUPANCY_EN.

## Operation
- State: circular storage of NUM_SLOTS entries, rd_ptr, wr_ptr, count. The storage array is not reset.
- Pointers advance by 1 per pop or push and wrap from NUM_SLOTS-1 to 0, including non-power-of-two depths.
- push = ins_valid & ins_ready. pop = outs_valid & outs_ready.
- ins_ready = (count != NUM_SLOTS).
  - It depends only on state, so there is no combinational path from outs_ready to ins_ready in either mode.
  - It is 0 while rst is low.
- Opaque mode (TRANSPARENT=0):
  - outs_valid = (count != 0).
  - outs = storage[rd_ptr].
  - Each push writes the storage. count changes by +1 (push only), -1 (pop only), or 0 (both).
- Transparent mode (TRANSPARENT=1):
  - When count==0: outs = ins and outs_valid = ins_valid.
  - A bypassed token that is popped in the same cycle is not written. If it is not popped, it is written and count becomes 1.
  - When count!=0: behaves as opaque. New tokens queue behind stored ones, so order is preserved.
- Boundary cases:
  - Full: no push. A pop frees a slot, and ins_ready rises in the next cycle.
  - Empty with no ins_valid: outs_valid=0. outs is don't-care and the bench must not check it.
  - Full with outs_ready=1: pop only.
  - NUM_SLOTS=1: a single slot with throughput 1/2 in opaque mode. This is legal.
- Token order is strictly FIFO. No token is dropped or duplicated.
- outs is held stable while outs_valid=1 and outs_ready=0.

## Timing
- Reset (rst low, asynchronous): count=0, rd_ptr=0, wr_ptr=0, outs_valid=0, ins_ready=0, occupancy=0.
- First edge after rst rises: ins_ready=1.
- Reset asserted mid-operation: all stored tokens are discarded immediately. No output handshake completes while rst is low.
- Opaque latency: a token pushed at edge N is offered on outs from edge N onward, i.e. valid in cycle N+1.
- Transparent latency when empty: 0 cycles, combinational ins→outs and ins_valid→outs_valid.
- Throughput: one token per cycle sustained when NUM_SLOTS≥2, or in transparent mode with an always-ready consumer.
- occupancy is registered and equals count.

## Configuration
- ELASTIC_FIFO_BUFFER_OCCUPANCY_EN
  - Defined: the occupancy port and its output logic are present.
  - Undefined: the port is absent, and the count logic is sized only for full/empty detection.
- Handshake behaviour is identical in both cases.

## Test plan
- Reset: hold rst low with ins_valid=1 → ins_ready=0, outs_valid=0, occupancy=0. Release rst → ins_ready=1 at the next edge.
- Opaque streaming: NUM_SLOTS=2, outs_ready=1, push 0x1..0x8 back-to-back → outs yields 0x1..0x8 in order, starting 1 cycle later, one per cycle.
- Fill and backpressure: NUM_SLOTS=3, outs_ready=0, push 0xA,0xB,0xC,0xD → first three accepted, ins_ready=0, occupancy=3, 0xD held. Raise outs_ready for one cycle → 0xA popped, 0xD accepted on the following edge.
- Wrap-around: NUM_SLOTS=3, random valid/ready for 1000 tokens → output sequence equals input sequence, occupancy never exceeds 3.
- Transparent bypass: TRANSPARENT=1, empty, outs_ready=1, ins=0x55 valid → outs=0x55 in the same cycle, occupancy stays 0. With outs_ready=0 → occupancy=1, and 0x55 is retained and delivered first.
- Reset mid-operation: occupancy=2, drive rst low for 1 cycle → outs_valid=0 immediately. After release, the next pushed token 0x99 is the first token out.
